// File: rtl/window_3x3_if.sv
`default_nettype none
// ============================================================================
//  Module   : window_3x3_if
//  Purpose  : Pixel-stream-in / window-out bundle for the 3x3 neighbourhood
//             generator.
//  Signals  : en, hsync, vsync, data       - pixel stream (master -> slave)
//             window, valid, x_out, y_out,
//             overflow                     - window result (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface window_3x3_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COORD_WIDTH = 11
);
  logic                    en;
  logic                    hsync;
  logic                    vsync;
  logic [DATA_WIDTH-1:0]   data;
  logic [9*DATA_WIDTH-1:0] window;
  logic                    valid;
  logic [COORD_WIDTH-1:0]  x_out;
  logic [COORD_WIDTH-1:0]  y_out;
  logic                    overflow;

  modport master (
    output en, hsync, vsync, data,
    input  window, valid, x_out, y_out, overflow
  );

  modport slave (
    input  en, hsync, vsync, data,
    output window, valid, x_out, y_out, overflow
  );
endinterface
`default_nettype wire

// File: rtl/window_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : window_3x3
//  Purpose  : Streaming 3x3 neighbourhood generator. Two line buffers feed a
//             3x3 shift window; each accepted pixel yields a registered window
//             centred one row up and one column left of that pixel.
//  Ports    : clk   - system clock, all logic on posedge
//             reset - synchronous active-high reset
//             bus   - window_3x3_if.slave (pixel stream in, window out)
//  Revision : 1.0  initial release
// ============================================================================
module window_3x3 #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_WIDTH   = 1024,
  parameter int COORD_WIDTH = 11
) (
  input wire          clk,
  input wire          reset,
  window_3x3_if.slave bus
);

  localparam int                     c_ADDR_W    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [COORD_WIDTH-1:0] c_COORD_MAX = '1;
  localparam logic [COORD_WIDTH-1:0] c_ONE       = COORD_WIDTH'(1);
  localparam logic [COORD_WIDTH-1:0] c_TWO       = COORD_WIDTH'(2);
  // One extra bit so a MAX_WIDTH equal to 2^COORD_WIDTH still compares correctly.
  localparam logic [COORD_WIDTH:0]   c_MAX_W     = (COORD_WIDTH+1)'(MAX_WIDTH);

  logic [COORD_WIDTH-1:0] r_row;
  logic [COORD_WIDTH-1:0] r_col;
  logic [DATA_WIDTH-1:0]  r_win [9];
  logic                   r_valid;
  logic [COORD_WIDTH-1:0] r_x;
  logic [COORD_WIDTH-1:0] r_y;
  logic                   r_ovf;

  // Line buffers: lb0 holds the previous line, lb1 the one before it.
  // Not reset; stale contents only ever reach the window while valid is low.
  logic [DATA_WIDTH-1:0]  r_lb0 [MAX_WIDTH];
  logic [DATA_WIDTH-1:0]  r_lb1 [MAX_WIDTH];

  logic [COORD_WIDTH-1:0] w_row;
  logic [COORD_WIDTH-1:0] w_col;
  logic                   w_in_range;
  logic [c_ADDR_W-1:0]    w_addr;
  logic [DATA_WIDTH-1:0]  w_top;
  logic [DATA_WIDTH-1:0]  w_mid;
  logic                   w_valid_next;

  // Position of the pixel currently on the bus; vsync outranks hsync, and an
  // hsync at column 0 (first line of a frame) does not advance the row.
  always_comb begin
    w_row = r_row;
    w_col = r_col;
    if (bus.vsync) begin
      w_row = '0;
      w_col = '0;
    end else if (bus.hsync) begin
      w_col = '0;
      if (r_col != '0 && r_row != c_COORD_MAX) begin
        w_row = r_row + c_ONE;
      end
    end
  end

  assign w_in_range   = ({1'b0, w_col} < c_MAX_W);
  assign w_addr       = w_col[c_ADDR_W-1:0];
  assign w_top        = r_lb1[w_addr];
  assign w_mid        = r_lb0[w_addr];
  assign w_valid_next = (w_row >= c_TWO) && (w_col >= c_TWO) && w_in_range;

  // Read taps above are taken before these writes land, so the window sees
  // the old column contents while the buffers roll down by one line.
  always_ff @(posedge clk) begin
    if (!reset && bus.en && w_in_range) begin
      r_lb1[w_addr] <= r_lb0[w_addr];
      r_lb0[w_addr] <= bus.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row   <= '0;
      r_col   <= '0;
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_ovf   <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        r_win[k] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      if (bus.en) begin
        r_row <= w_row;
        r_col <= (w_col == c_COORD_MAX) ? w_col : w_col + c_ONE;
        r_x   <= w_col - c_ONE;
        r_y   <= w_row - c_ONE;
        if (bus.vsync) begin
          r_ovf <= 1'b0;
        end else if (!w_in_range) begin
          r_ovf <= 1'b1;
        end
        // Pixels beyond the line buffers are dropped: window frozen.
        if (w_in_range) begin
          for (int i = 0; i < 3; i++) begin
            r_win[3*i]   <= r_win[3*i+1];
            r_win[3*i+1] <= r_win[3*i+2];
          end
          r_win[2] <= w_top;
          r_win[5] <= w_mid;
          r_win[8] <= bus.data;
          r_valid  <= w_valid_next;
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < 9; k++) begin : g_win
      assign bus.window[k*DATA_WIDTH +: DATA_WIDTH] = r_win[k];
    end
  endgenerate

  assign bus.valid    = r_valid;
  assign bus.x_out    = r_x;
  assign bus.y_out    = r_y;
  assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_window_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_3x3
//  Purpose  : Directed self-checking bench for window_3x3. Instance u_dut uses
//             the full-size line buffers; u_dut4 uses MAX_WIDTH=4 for the
//             overflow scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_window_3x3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   nvalid;
  int   lastx, lasty;
  logic [71:0] held_win;
  logic [10:0] held_x, held_y;

  always #5 clk = ~clk;

  window_3x3_if #(.DATA_WIDTH(8), .COORD_WIDTH(11)) ifa ();
  window_3x3_if #(.DATA_WIDTH(8), .COORD_WIDTH(11)) ifb ();

  window_3x3 #(.DATA_WIDTH(8), .MAX_WIDTH(1024), .COORD_WIDTH(11)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  window_3x3 #(.DATA_WIDTH(8), .MAX_WIDTH(4), .COORD_WIDTH(11)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Window for centre pixel (r-1, c-1) of a frame whose pixel is base+16*row+col.
  function automatic logic [71:0] expwin(input int base, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w[8*(3*i+j) +: 8] = 8'(base + 16*(r-2+i) + (c-2+j));
      end
    end
    return w;
  endfunction

  task automatic pa(input logic e, input logic h, input logic v, input logic [7:0] d);
    ifa.en = e; ifa.hsync = h; ifa.vsync = v; ifa.data = d;
    @(posedge clk); #1;
  endtask

  task automatic pb(input logic e, input logic h, input logic v, input logic [7:0] d);
    ifb.en = e; ifb.hsync = h; ifb.vsync = v; ifb.data = d;
    @(posedge clk); #1;
  endtask

  // Checks the output registered for pixel (r,c) of a 5-wide frame.
  task automatic check_pix(input string tag, input int base, input int r, input int c);
    if (r >= 2 && c >= 2) begin
      check($sformatf("%s valid r%0d c%0d", tag, r, c), ifa.valid, 1);
      check($sformatf("%s win r%0d c%0d", tag, r, c), ifa.window, expwin(base, r, c));
      check($sformatf("%s x r%0d c%0d", tag, r, c), ifa.x_out, c-1);
      check($sformatf("%s y r%0d c%0d", tag, r, c), ifa.y_out, r-1);
    end else begin
      check($sformatf("%s novalid r%0d c%0d", tag, r, c), ifa.valid, 0);
    end
    if (ifa.valid) begin
      nvalid++;
      lastx = int'(ifa.x_out);
      lasty = int'(ifa.y_out);
    end
  endtask

  initial begin
    reset = 1'b1;
    ifa.en = 0; ifa.hsync = 0; ifa.vsync = 0; ifa.data = '0;
    ifb.en = 0; ifb.hsync = 0; ifb.vsync = 0; ifb.data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst window", ifa.window, 0);
    check("rst valid", ifa.valid, 0);
    check("rst x", ifa.x_out, 0);
    check("rst y", ifa.y_out, 0);
    check("rst overflow", ifa.overflow, 0);
    reset = 1'b0;

    // Frame A: 5x4, continuous, vsync alone on (0,0), hsync on later line starts.
    nvalid = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        pa(1, (c == 0 && r != 0), (r == 0 && c == 0), 8'(16*r + c));
        check_pix("A", 0, r, c);
      end
    end
    check("A valid count", nvalid, 6);
    check("A last x", lastx, 3);
    check("A last y", lasty, 2);

    // Frame B back-to-back, vsync+hsync together, en toggling with junk on idle cycles.
    nvalid = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        pa(1, (c == 0), (r == 0 && c == 0), 8'(8'h80 + 16*r + c));
        check_pix("B", 8'h80, r, c);
        held_win = ifa.window;
        held_x   = ifa.x_out;
        held_y   = ifa.y_out;
        pa(0, 1, 1, 8'hFF);
        check($sformatf("B idle valid r%0d c%0d", r, c), ifa.valid, 0);
        check($sformatf("B idle win r%0d c%0d", r, c), ifa.window, held_win);
        check($sformatf("B idle x r%0d c%0d", r, c), ifa.x_out, held_x);
        check($sformatf("B idle y r%0d c%0d", r, c), ifa.y_out, held_y);
      end
    end
    check("B valid count", nvalid, 6);

    // Frame C interrupted by a one-cycle reset in row 3.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (r < 3 || c < 2) begin
          pa(1, (c == 0 && r != 0), (r == 0 && c == 0), 8'(8'h40 + 16*r + c));
        end
      end
    end
    reset = 1'b1;
    pa(1, 0, 0, 8'h55);
    reset = 1'b0;
    check("C rst window", ifa.window, 0);
    check("C rst valid", ifa.valid, 0);
    check("C rst x", ifa.x_out, 0);
    check("C rst y", ifa.y_out, 0);
    check("C rst overflow", ifa.overflow, 0);
    // First pixel after reset carries no sync and must still land at (0,0).
    nvalid = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 5; c++) begin
        pa(1, (c == 0 && r != 0), 0, 8'(8'h20 + 16*r + c));
        check_pix("C", 8'h20, r, c);
      end
    end
    check("C valid count", nvalid, 3);
    pa(0, 0, 0, 8'h00);

    // Overflow on the MAX_WIDTH=4 instance: lines of 6 pixels.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 6; c++) begin
        pb(1, (c == 0 && r != 0), (r == 0 && c == 0), 8'(16*r + c));
        if (r == 0 && c == 3) begin
          check("OV before", ifb.overflow, 0);
          held_win = ifb.window;
        end
        if (r == 0 && c == 4) begin
          check("OV set", ifb.overflow, 1);
          check("OV drop valid", ifb.valid, 0);
          check("OV drop win c4", ifb.window, held_win);
        end
        if (r == 0 && c == 5) begin
          check("OV drop win c5", ifb.window, held_win);
        end
        if (r == 1 && c == 0) begin
          check("OV sticky hsync", ifb.overflow, 1);
        end
        if (r == 2 && (c == 2 || c == 3)) begin
          check($sformatf("OV r2 valid c%0d", c), ifb.valid, 1);
          check($sformatf("OV r2 win c%0d", c), ifb.window, expwin(0, 2, c));
          check($sformatf("OV r2 x c%0d", c), ifb.x_out, c-1);
        end
        if (r == 2 && c >= 4) begin
          check($sformatf("OV r2 novalid c%0d", c), ifb.valid, 0);
        end
      end
    end
    pb(1, 0, 1, 8'h00);
    check("OV cleared by vsync", ifb.overflow, 0);
    check("OV vsync novalid", ifb.valid, 0);
    pb(0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/window_3x3.md
Name: window_3x3

Overview:
- Streaming 3x3 neighbourhood generator, directly downstream of the pixel input port of `top` (clk/reset/en/hsync/vsync/data stream, one pixel per cycle).
- Holds two line buffers and a 3x3 shift window.
- Each accepted pixel produces a registered 3x3 window centred one row up and one column left, with a valid flag and centre coordinates.
- Feeds the kernel stages (Sobel/threshold) that follow it.

Parameters:
- DATA_WIDTH, 8: bits per pixel (grayscale intensity).
- MAX_WIDTH, 1024: line-buffer depth; maximum supported line length in pixels.
- COORD_WIDTH, 11: width of the row/column counters and the coordinate outputs.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  pixel-accept strobe; `data`/`hsync`/`vsync` sampled only when en=1.
- hsync  in  1  qualifies `data` as the first pixel of a line.
- vsync  in  1  qualifies `data` as the first pixel of a frame.
- data  in  DATA_WIDTH  input pixel.
- window  out  9*DATA_WIDTH  `window[DATA_WIDTH*(3*i+j) +: DATA_WIDTH]` = row i (0=top), column j (0=left).
- valid  out  1  window holds a complete 3x3 neighbourhood.
- x_out  out  COORD_WIDTH  column of the window centre.
- y_out  out  COORD_WIDTH  row of the window centre.
- overflow  out  1  sticky: a line exceeded MAX_WIDTH.

Behaviour:
- Reset (synchronous, reset=1 at posedge): window=0, valid=0, x_out=0, y_out=0, overflow=0, row_q=0, col_q=0. Line-buffer RAM is not cleared; stale contents are masked by the valid gating.
- Position of an accepted pixel (en=1), in priority order:
  - vsync=1: (row 0, col 0). vsync wins over simultaneous hsync.
  - else hsync=1 and col_q!=0: (row_q+1, col 0).
  - else hsync=1 and col_q==0: (row_q, col 0). This covers the first line after reset or vsync.
  - else: (row_q, col_q).
- After acceptance: row_q <= pixel row; col_q <= pixel col+1. row_q saturates at 2^COORD_WIDTH-1.
- Line buffers for an accepted pixel at column c < MAX_WIDTH:
  - Read taps: top = lb1[c], mid = lb0[c].
  - Writes: lb1[c] <= lb0[c]; lb0[c] <= data.
  - Read-before-write in the same cycle.
- Window update: columns shift left by one; new column 2 = {top, mid, data} for rows 0, 1, 2. The shift also occurs at col 0; stale columns are masked by valid.
- Output timing (latency 1 cycle): on the cycle after acceptance of pixel (r, c):
  - valid = (r>=2 && c>=2 && c<MAX_WIDTH).
  - x_out = c-1, y_out = r-1.
- en=0: no RAM write, no counter change, window/x_out/y_out hold, valid=0 on the next cycle.
- Overflow: a pixel with c>=MAX_WIDTH is dropped (no RAM write, no window shift, valid=0) and sets overflow=1. col_q keeps counting, saturating. overflow clears only on reset or an accepted vsync.
- Reset asserted mid-line: all state returns to reset values on that edge. The next accepted pixel is (0,0) regardless of sync inputs.
- No backpressure: the downstream stage must accept every valid cycle.

Test Plan:
- 5x4 frame, data = 16*row+col, vsync on (0,0), hsync on each line start, en=1 continuous:
  - valid first rises the cycle after pixel (2,2), with x_out=1, y_out=1 and window rows {0x00,0x01,0x02 / 0x10,0x11,0x12 / 0x20,0x21,0x22}.
  - Exactly 6 valid cycles in total.
- Same frame with en toggling 1,0,1,0:
  - Identical sequence of valid windows and coordinates.
  - valid=0 and window held on every en=0 cycle.
- vsync and hsync together on the first pixel of the second frame:
  - Row resets to 0; no valid output for frame-2 rows 0–1.
  - Frame-2 row-2 windows contain only frame-2 data.
- MAX_WIDTH=4, line of 6 pixels:
  - Pixels at c=4,5 dropped; overflow=1 and stays 1 after the next hsync.
  - overflow clears on the next vsync.
- reset pulsed for one cycle mid-row 3:
  - All outputs 0 the next cycle.
  - The following pixel is treated as (0,0); no valid until the third row after the reset.
- Back-to-back frames at 1 pixel/cycle:
  - No bubble; the last valid of frame 1 is at x_out=3, y_out=2.
  - No valid for the first two rows of frame 2.
